// File: rtl/blk_arb_pkg.sv
// Shared types and constants for the two-channel begin/end word arbiter.
package blk_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic [7:0]  ASCII_SPACE = 8'h20;
  localparam logic [7:0]  CASE_MASK   = 8'h20;
  localparam logic [39:0] KW_BEGIN    = "begin";
  localparam logic [23:0] KW_END      = "end";

  function automatic logic [7:0] kw_begin_char(input logic [2:0] idx);
    case (idx)
      3'd0:    return KW_BEGIN[39:32];
      3'd1:    return KW_BEGIN[31:24];
      3'd2:    return KW_BEGIN[23:16];
      3'd3:    return KW_BEGIN[15:8];
      3'd4:    return KW_BEGIN[7:0];
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] kw_end_char(input logic [2:0] idx);
    case (idx)
      3'd0:    return KW_END[23:16];
      3'd1:    return KW_END[15:8];
      3'd2:    return KW_END[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/blk_word_matcher.sv
// Case-insensitive "begin"/"end" recognizer over a space-terminated word.
module blk_word_matcher
  import blk_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ch,
  input  logic       ch_en,
  output logic       word_done,
  output logic       is_begin,
  output logic       is_end
);

  logic [2:0] len_q, len_d;
  logic       beg_miss_q, beg_miss_d;
  logic       end_miss_q, end_miss_d;
  logic [7:0] lc;

  assign lc        = ch | CASE_MASK;
  assign word_done = ch_en && (ch == ASCII_SPACE);
  assign is_begin  = word_done && !beg_miss_q && (len_q == 3'd5);
  assign is_end    = word_done && !end_miss_q && (len_q == 3'd3);

  // Miss flags record any divergence from the keyword prefix; length saturates at 6.
  always_comb begin
    len_d      = len_q;
    beg_miss_d = beg_miss_q;
    end_miss_d = end_miss_q;
    if (word_done) begin
      len_d      = '0;
      beg_miss_d = 1'b0;
      end_miss_d = 1'b0;
    end else if (ch_en) begin
      if ((len_q >= 3'd5) || (lc != kw_begin_char(len_q))) beg_miss_d = 1'b1;
      if ((len_q >= 3'd3) || (lc != kw_end_char(len_q)))   end_miss_d = 1'b1;
      if (len_q != 3'd6) len_d = len_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q      <= '0;
      beg_miss_q <= 1'b0;
      end_miss_q <= 1'b0;
    end else begin
      len_q      <= len_d;
      beg_miss_q <= beg_miss_d;
      end_miss_q <= end_miss_d;
    end
  end

endmodule

// File: rtl/blk_word_arbiter.sv
// Word-granular arbiter sharing one keyword matcher between two character streams.
// Define BLK_ARB_FAIR_EN for round-robin tie breaking; otherwise channel 0 wins ties.
module blk_word_arbiter
  import blk_arb_pkg::*;
#(
  parameter int unsigned DEPTH_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in0,
  input  logic       in0_valid,
  output logic       in0_ready,
  input  logic [7:0] in1,
  input  logic       in1_valid,
  output logic       in1_ready,
  output logic [1:0] grant,
  output logic       busy,
  output logic [1:0] result,
  output logic [1:0] err
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  arb_state_e                   state_q, state_d;
  logic [1:0][DEPTH_W-1:0]      depth_q, depth_d;
  logic [1:0]                   err_q, err_d;
  logic [1:0]                   result_q, result_d;
  logic                         own;
  logic [7:0]                   cur_ch;
  logic                         ch_en;
  logic                         word_done, is_begin, is_end;
  logic                         tie_pick1;

  assign own    = (state_q == OWN1);
  assign cur_ch = own ? in1 : in0;
  assign ch_en  = ((state_q == OWN0) && in0_valid) || ((state_q == OWN1) && in1_valid);

  blk_word_matcher u_matcher (
    .clk      (clk),
    .reset    (reset),
    .ch       (cur_ch),
    .ch_en    (ch_en),
    .word_done(word_done),
    .is_begin (is_begin),
    .is_end   (is_end)
  );

`ifdef BLK_ARB_FAIR_EN
  logic last_q, last_d;

  // Pointer holds the channel that owned the most recently completed word.
  assign tie_pick1 = ~last_q;

  always_comb begin
    last_d = last_q;
    if (word_done) last_d = own;
  end

  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`else
  assign tie_pick1 = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in0_valid && in1_valid) state_d = tie_pick1 ? OWN1 : OWN0;
        else if (in0_valid)         state_d = OWN0;
        else if (in1_valid)         state_d = OWN1;
      end
      OWN0, OWN1: if (word_done) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    depth_d  = depth_q;
    err_d    = err_q;
    result_d = result_q;
    if (is_begin) begin
      if (depth_q[own] == DEPTH_MAX) err_d[own] = 1'b1;
      else                           depth_d[own] = depth_q[own] + DEPTH_W'(1);
    end
    if (is_end) begin
      if (depth_q[own] == '0) err_d[own] = 1'b1;
      else                    depth_d[own] = depth_q[own] - DEPTH_W'(1);
    end
    for (int unsigned i = 0; i < 2; i++) begin
      result_d[i] = (depth_d[i] == '0) && !err_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      depth_q  <= '0;
      err_q    <= '0;
      result_q <= '1;
    end else begin
      state_q  <= state_d;
      depth_q  <= depth_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign in0_ready = (state_q == OWN0);
  assign in1_ready = (state_q == OWN1);
  assign grant     = {state_q == OWN1, state_q == OWN0};
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign err       = err_q;

endmodule
